// File: rtl/pusch_scr_pkg.sv
// ---------------------------------------------------------------------------
// pusch_scr_pkg
// Shared definitions for the PUSCH bit scrambler:
//   - scr_state_t : controller state encoding (IDLE, WARMUP, RUN, DONE)
//   - LFSR_W      : width of each Gold-sequence LFSR (31)
//   - X1_SEED     : fixed x1 initial state, x1(0)=1 and x1(1..30)=0
//   - TAG_*       : x/y tag codes for the optional data_tag feature
// ---------------------------------------------------------------------------
package pusch_scr_pkg;

    localparam int LFSR_W = 31;

    localparam logic [LFSR_W-1:0] X1_SEED = 31'h1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WARMUP = 2'd1,
        RUN    = 2'd2,
        DONE   = 2'd3
    } scr_state_t;

    localparam logic [1:0] TAG_NORMAL = 2'd0;
    localparam logic [1:0] TAG_X      = 2'd1;
    localparam logic [1:0] TAG_Y      = 2'd2;
    localparam logic [1:0] TAG_RSVD   = 2'd3;

endpackage

// File: rtl/pusch_scrambler_gold_lfsr_step.sv
// ---------------------------------------------------------------------------
// gold_lfsr_step
// Purely combinational: advances the Gold-sequence LFSR pair (x1, x2) by
// STEPS single-bit steps. Bit 0 of each register holds x(n); a step shifts
// right by one and the feedback bit enters bit 30.
// Ports:
//   x1_in, x2_in   : current LFSR states
//   x1_out, x2_out : states after STEPS steps
// ---------------------------------------------------------------------------
module gold_lfsr_step
    import pusch_scr_pkg::*;
#(
    parameter int STEPS = 1
) (
    input  logic [LFSR_W-1:0] x1_in,
    input  logic [LFSR_W-1:0] x2_in,
    output logic [LFSR_W-1:0] x1_out,
    output logic [LFSR_W-1:0] x2_out
);

    // Unrolled chain of STEPS shifts; x1(n+31) = x1(n+3) ^ x1(n) and
    // x2(n+31) = x2(n+3) ^ x2(n+2) ^ x2(n+1) ^ x2(n).
    always_comb begin
        x1_out = x1_in;
        x2_out = x2_in;
        for (int s = 0; s < STEPS; s++) begin
            x1_out = {x1_out[0] ^ x1_out[3], x1_out[LFSR_W-1:1]};
            x2_out = {x2_out[0] ^ x2_out[1] ^ x2_out[2] ^ x2_out[3],
                      x2_out[LFSR_W-1:1]};
        end
    end

endmodule

// File: rtl/pusch_scrambler.sv
// ---------------------------------------------------------------------------
// pusch_scrambler
// Bit-serial PUSCH scrambler. XORs each incoming interleaved bit with the
// Gold sequence c(i) seeded by c_init, after an NC-step warm-up that runs
// WARMUP_PAR steps per cycle. One cycle latency from valid_in to valid_out.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   start       : pulse, latches c_init and E (ignored when E==0)
//   c_init, E   : scrambling seed, codeword length in bits
//   data_in     : interleaved bit, qualified by valid_in
//   data_tag    : x/y bit tag (only with the optional tag macro defined)
//   data_out    : scrambled bit, qualified by valid_out
//   ready       : high while bits are accepted
//   done        : one-cycle pulse the cycle after the last bit is output
//   err_early   : sticky flag, valid_in seen while not accepting bits
// The optional tag macro adds x/y repetition-bit handling.
// ---------------------------------------------------------------------------
module pusch_scrambler
    import pusch_scr_pkg::*;
#(
    parameter int NC         = 1600,
    parameter int WARMUP_PAR = 16,
    parameter int E_W        = 17
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [30:0]       c_init,
    input  logic [E_W-1:0]    E,
    input  logic              data_in,
`ifdef SCR_PLACEHOLDER_EN
    input  logic [1:0]        data_tag,
`endif
    input  logic              valid_in,
    output logic              data_out,
    output logic              valid_out,
    output logic              ready,
    output logic              done,
    output logic              err_early
);

    localparam int WARM_CYCLES = NC / WARMUP_PAR;
    localparam int WARM_W      = (WARM_CYCLES > 1) ? $clog2(WARM_CYCLES) : 1;
    localparam logic [WARM_W-1:0] WARM_LAST =
        WARM_W'((WARM_CYCLES > 0) ? WARM_CYCLES - 1 : 0);
    localparam scr_state_t START_STATE = (NC == 0) ? RUN : WARMUP;

    scr_state_t        state;
    scr_state_t        state_next;
    logic [LFSR_W-1:0] x1;
    logic [LFSR_W-1:0] x2;
    logic [LFSR_W-1:0] x1_warm;
    logic [LFSR_W-1:0] x2_warm;
    logic [LFSR_W-1:0] x1_one;
    logic [LFSR_W-1:0] x2_one;
    logic [E_W-1:0]    e_reg;
    logic [E_W-1:0]    bit_cnt;
    logic [WARM_W-1:0] warm_cnt;
    logic              start_ok;
    logic              accept;
    logic              last_bit;
    logic              c_bit;
    logic              scr_bit;
`ifdef SCR_PLACEHOLDER_EN
    logic              prev_bit;
`endif

    gold_lfsr_step #(.STEPS(WARMUP_PAR)) u_step_warm (
        .x1_in  (x1),
        .x2_in  (x2),
        .x1_out (x1_warm),
        .x2_out (x2_warm)
    );

    gold_lfsr_step #(.STEPS(1)) u_step_one (
        .x1_in  (x1),
        .x2_in  (x2),
        .x1_out (x1_one),
        .x2_out (x2_one)
    );

    // A start with E==0 is treated as no start at all. A valid start always
    // wins over a bit arriving in the same cycle, so that bit is dropped.
    assign start_ok = start && (E != '0);
    assign accept   = (state == RUN) && valid_in && !start_ok;
    assign last_bit = (bit_cnt + E_W'(1)) == e_reg;
    assign c_bit    = x1[0] ^ x2[0];
    assign ready    = (state == RUN);

    // Output bit selection; x/y tags override the scrambled value.
    always_comb begin
        scr_bit = data_in ^ c_bit;
`ifdef SCR_PLACEHOLDER_EN
        case (data_tag)
            TAG_X:   scr_bit = 1'b1;
            TAG_Y:   scr_bit = prev_bit;
            default: scr_bit = data_in ^ c_bit;
        endcase
`endif
    end

    // Next-state logic; a valid start restarts the word from any state.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = state;
            WARMUP:  if (warm_cnt == WARM_LAST) state_next = RUN;
            RUN:     if (accept && last_bit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (start_ok) begin
            state_next = START_STATE;
        end
    end

    // State, LFSRs, counters and registered outputs. done is suppressed if
    // a new word starts in the DONE cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            x1        <= '0;
            x2        <= '0;
            e_reg     <= '0;
            bit_cnt   <= '0;
            warm_cnt  <= '0;
            data_out  <= 1'b0;
            valid_out <= 1'b0;
            done      <= 1'b0;
            err_early <= 1'b0;
`ifdef SCR_PLACEHOLDER_EN
            prev_bit  <= 1'b0;
`endif
        end else begin
            state     <= state_next;
            valid_out <= accept;
            done      <= (state == DONE) && !start_ok;
            if (start_ok) begin
                x1        <= X1_SEED;
                x2        <= c_init;
                e_reg     <= E;
                bit_cnt   <= '0;
                warm_cnt  <= '0;
                err_early <= 1'b0;
`ifdef SCR_PLACEHOLDER_EN
                prev_bit  <= 1'b0;
`endif
            end else begin
                if (valid_in && (state != RUN)) begin
                    err_early <= 1'b1;
                end
                if (state == WARMUP) begin
                    x1       <= x1_warm;
                    x2       <= x2_warm;
                    warm_cnt <= warm_cnt + WARM_W'(1);
                end
                if (accept) begin
                    x1       <= x1_one;
                    x2       <= x2_one;
                    bit_cnt  <= bit_cnt + E_W'(1);
                    data_out <= scr_bit;
`ifdef SCR_PLACEHOLDER_EN
                    prev_bit <= scr_bit;
`endif
                end
            end
        end
    end

endmodule
